// File: rtl/multicycle_data_path.sv
// Multicycle RISC-style datapath: FETCH -> DECODE -> EXEC -> {MEM} -> WB, one instruction in flight.
// Control signals come from an external decoder and are consumed only in EXEC, MEM and WB.
module multicycle_data_path #(
  parameter int unsigned PC_W       = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned ALU_CC_W   = 4,
  parameter int unsigned PC_STEP    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic                  mem2reg,
  input  logic                  alu_src,
  input  logic                  mem_write,
  input  logic                  mem_read,
  input  logic                  branch,
  input  logic [ALU_CC_W-1:0]   alu_cc,
  output logic [6:0]            opcode,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output logic [PC_W-1:0]       imem_addr,
  output logic                  imem_req,
  input  logic [31:0]           imem_rdata,
  input  logic                  imem_ready,
  output logic [DM_ADDRESS-1:0] dmem_addr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ready,
  output logic [DATA_W-1:0]     alu_result,
  output logic                  retire
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  localparam logic [ALU_CC_W-1:0] CC_AND = ALU_CC_W'(4'b0000);
  localparam logic [ALU_CC_W-1:0] CC_OR  = ALU_CC_W'(4'b0001);
  localparam logic [ALU_CC_W-1:0] CC_ADD = ALU_CC_W'(4'b0010);
  localparam logic [ALU_CC_W-1:0] CC_SUB = ALU_CC_W'(4'b0110);
  localparam logic [ALU_CC_W-1:0] CC_SLT = ALU_CC_W'(4'b0111);
  localparam logic [ALU_CC_W-1:0] CC_NOR = ALU_CC_W'(4'b1100);

  state_t            state, state_n;
  logic [PC_W-1:0]   pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a, b, alu_out, mdr;
  logic [DATA_W-1:0] rf [32];

  logic [4:0]        rs1, rs2, rd;
  logic [DATA_W-1:0] rs1_val, rs2_val;
  logic [11:0]       imm_i, imm_s;
  logic [12:0]       imm_b;
  logic [DATA_W-1:0] imm, op_b, alu_y, wb_val;
  logic [PC_W-1:0]   pc_seq, pc_br;

  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf[rs2];

  // IR is frozen from DECODE to retire, so forming the immediate here with the
  // EXEC-time controls is equivalent to latching it in DECODE, and keeps the
  // controls from being consulted before EXEC.
  assign imm_i = ir[31:20];
  assign imm_s = {ir[31:25], ir[11:7]};
  assign imm_b = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  always_comb begin
    imm = {{(DATA_W-12){imm_i[11]}}, imm_i};
    if (branch)
      imm = {{(DATA_W-13){imm_b[12]}}, imm_b};
    else if (mem_write)
      imm = {{(DATA_W-12){imm_s[11]}}, imm_s};
  end

  assign op_b = alu_src ? imm : b;

  always_comb begin
    alu_y = '0;
    unique case (alu_cc)
      CC_AND:  alu_y = a & op_b;
      CC_OR:   alu_y = a | op_b;
      CC_ADD:  alu_y = a + op_b;
      CC_SUB:  alu_y = a - op_b;
      CC_SLT:  alu_y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(op_b))};
      CC_NOR:  alu_y = ~(a | op_b);
      default: alu_y = '0;
    endcase
  end

  assign pc_seq = pc + PC_W'(PC_STEP);
  assign pc_br  = pc + imm[PC_W-1:0];
  assign wb_val = mem2reg ? mdr : alu_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      FETCH:   if (imem_ready) state_n = DECODE;
      DECODE:  state_n = EXEC;
      EXEC: begin
        if (branch)                      state_n = FETCH;
        else if (mem_read || mem_write)  state_n = MEM;
        else                             state_n = WB;
      end
      MEM:     if (dmem_ready) state_n = WB;
      WB:      state_n = FETCH;
      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      unique case (state)
        FETCH:  if (imem_ready) ir <= imem_rdata;
        DECODE: begin
          a <= rs1_val;
          b <= rs2_val;
        end
        EXEC: begin
          alu_out <= alu_y;
          if (branch) pc <= (a == b) ? pc_br : pc_seq;
        end
        MEM:    if (dmem_ready && mem_read && !mem_write) mdr <= dmem_rdata;
        WB:     pc <= pc_seq;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == WB && reg_write && rd != 5'd0) begin
      rf[rd] <= wb_val;
    end
  end

  // Fetch request is held off while reset is asserted and re-raised on release.
  assign imem_req   = (state == FETCH) && reset;
  assign imem_addr  = pc;
  assign dmem_req   = (state == MEM);
  assign dmem_we    = (state == MEM) && mem_write;
  assign dmem_addr  = alu_out[DM_ADDRESS-1:0];
  assign dmem_wdata = b;
  assign alu_result = alu_out;
  assign retire     = (state == WB) || (state == EXEC && branch);

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench for multicycle_data_path: a table of instructions with hand-computed
// fetch address, latency, ALU result and data-memory traffic, plus reset corner sequences.
module tb_multicycle_data_path;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write, mem2reg, alu_src, mem_write, mem_read, branch;
  logic [3:0]  alu_cc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [8:0]  dmem_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic [31:0] alu_result;
  logic        retire;

  multicycle_data_path #(
    .PC_W(8), .DATA_W(32), .DM_ADDRESS(9), .ALU_CC_W(4), .PC_STEP(4)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
    .mem_write(mem_write), .mem_read(mem_read), .branch(branch), .alu_cc(alu_cc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_addr(dmem_addr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .alu_result(alu_result), .retire(retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    bit          rw, m2r, asrc, mw, mr, br;
    logic [3:0]  cc;
    int          iwait, dwait;
    bit          late;
    int          cyc;
    logic [7:0]  pc;
    bit          chk_alu;
    logic [31:0] alu;
    bit          chk_dm, chk_wd;
    logic [8:0]  daddr;
    logic [31:0] dwdata;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] dmem_model [512];
  vec_t        tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t alu_row(logic [31:0] instr, logic [3:0] cc, bit asrc, bit rw,
                                   logic [7:0] pc, logic [31:0] alu);
    vec_t v;
    v = '{instr: instr, rw: rw, m2r: 1'b0, asrc: asrc, mw: 1'b0, mr: 1'b0, br: 1'b0,
          cc: cc, iwait: 0, dwait: 0, late: 1'b0, cyc: 4, pc: pc, chk_alu: 1'b1, alu: alu,
          chk_dm: 1'b0, chk_wd: 1'b0, daddr: '0, dwdata: '0};
    return v;
  endfunction

  function automatic vec_t br_row(logic [31:0] instr, logic [7:0] pc);
    vec_t v;
    v = alu_row(instr, 4'b0110, 1'b0, 1'b0, pc, '0);
    v.br = 1'b1; v.cyc = 3; v.chk_alu = 1'b0;
    return v;
  endfunction

  function automatic vec_t mem_row(logic [31:0] instr, bit store, logic [7:0] pc, int iw, int dw,
                                   logic [8:0] addr, logic [31:0] wdata);
    vec_t v;
    v = alu_row(instr, 4'b0010, 1'b1, !store, pc, 32'(addr));
    v.mw = store; v.mr = !store; v.m2r = !store;
    v.iwait = iw; v.dwait = dw; v.cyc = 5 + iw + dw;
    v.chk_dm = 1'b1; v.chk_wd = store; v.daddr = addr; v.dwdata = wdata;
    return v;
  endfunction

  task automatic set_ctrl(input vec_t v, input bit bogus);
    if (bogus) begin
      reg_write = 1'b0; mem2reg = 1'b1; alu_src = 1'b0;
      mem_write = 1'b1; mem_read = 1'b1; branch = 1'b1; alu_cc = 4'b1100;
    end else begin
      reg_write = v.rw; mem2reg = v.m2r; alu_src = v.asrc;
      mem_write = v.mw; mem_read = v.mr; branch = v.br; alu_cc = v.cc;
    end
  endtask

  // Called on a falling edge with the DUT in FETCH; returns on the falling edge after retire.
  task automatic run_row(input vec_t v, input string tag);
    int cyc = 0, iw = v.iwait, dw = v.dwait;
    bit done = 0, hold_ok = 1, seen_i = 0, seen_d = 0;
    logic [7:0] f_addr = '0;
    logic [8:0] d_addr = '0;
    logic d_we = 0;
    logic [31:0] d_wd = '0;
    imem_rdata = v.instr;
    while (!done && cyc < 40) begin
      cyc++;
      set_ctrl(v, v.late && cyc < 3);
      #1;
      if (imem_req) begin
        if (!seen_i) begin f_addr = imem_addr; seen_i = 1; end
        else if (imem_addr !== f_addr) hold_ok = 0;
        imem_ready = (iw == 0);
        if (iw > 0) iw--;
      end else imem_ready = 1'b0;
      if (dmem_req) begin
        if (!seen_d) begin d_addr = dmem_addr; d_we = dmem_we; d_wd = dmem_wdata; seen_d = 1; end
        else if (dmem_addr !== d_addr || dmem_we !== d_we || dmem_wdata !== d_wd) hold_ok = 0;
        dmem_rdata = dmem_model[dmem_addr];
        dmem_ready = (dw == 0);
        if (dw > 0) dw--;
        if (dmem_ready && dmem_we) dmem_model[dmem_addr] = dmem_wdata;
      end else dmem_ready = 1'b0;
      if (retire) done = 1;
      @(negedge clk);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_fetch_pc"}, 32'(f_addr), 32'(v.pc));
    check({tag, "_cycles"}, cyc, v.cyc);
    check({tag, "_fields"}, {15'd0, funct7, funct3, opcode},
          {15'd0, v.instr[31:25], v.instr[14:12], v.instr[6:0]});
    if (v.chk_alu) check({tag, "_alu"}, alu_result, v.alu);
    if (v.chk_dm) begin
      check({tag, "_dm_addr_we"}, {22'd0, d_we, d_addr}, {22'd0, v.mw, v.daddr});
      if (v.chk_wd) check({tag, "_dm_wdata"}, d_wd, v.dwdata);
    end
    if (v.iwait > 0 || v.dwait > 0) check({tag, "_hold"}, 32'(hold_ok), 32'd1);
  endtask

  initial begin
    bit got;
    reset = 1'b0;
    reg_write = 0; mem2reg = 0; alu_src = 0; mem_write = 0; mem_read = 0; branch = 0; alu_cc = '0;
    imem_rdata = '0; imem_ready = 0; dmem_rdata = '0; dmem_ready = 0;
    for (int i = 0; i < 512; i++) dmem_model[i] = '0;

    tbl.push_back(alu_row(32'h00500093, 4'b0010, 1, 1, 8'd0,  32'd5));        // ADDI x1,x0,5
    tbl.push_back(alu_row(32'h00108133, 4'b0010, 0, 1, 8'd4,  32'd10));       // ADD x2,x1,x1
    tbl.push_back(br_row (32'h00108463, 8'd8));                               // BEQ x1,x1,+8
    tbl.push_back(mem_row(32'h00202223, 1, 8'd16, 0, 0, 9'd4, 32'd10));       // SW x2,4(x0)
    tbl.push_back(mem_row(32'h00402183, 0, 8'd20, 0, 0, 9'd4, 32'd0));        // LW x3,4(x0)
    tbl.push_back(alu_row(32'h40118233, 4'b0110, 0, 1, 8'd24, 32'd5));        // SUB x4,x3,x1
    tbl.push_back(br_row (32'h00208463, 8'd28));                              // BEQ x1,x2 not taken
    tbl.push_back(mem_row(32'h00402283, 0, 8'd32, 3, 2, 9'd4, 32'd0));        // LW x5 with waits
    tbl.push_back(alu_row(32'h00028333, 4'b0010, 0, 1, 8'd36, 32'd10));       // ADD x6,x5,x0
    tbl.push_back(alu_row(32'h00700013, 4'b0010, 1, 1, 8'd40, 32'd7));        // ADDI x0,x0,7
    tbl.push_back(alu_row(32'h000003B3, 4'b0010, 0, 1, 8'd44, 32'd0));        // ADD x7,x0,x0
    tbl.push_back(alu_row(32'h00208033, 4'b0001, 0, 0, 8'd48, 32'h0000000F)); // OR
    tbl.push_back(alu_row(32'h00208033, 4'b0000, 0, 0, 8'd52, 32'h00000000)); // AND
    tbl.push_back(alu_row(32'h00208033, 4'b0110, 0, 0, 8'd56, 32'hFFFFFFFB)); // SUB
    tbl.push_back(alu_row(32'h00208033, 4'b1100, 0, 0, 8'd60, 32'hFFFFFFF0)); // NOR
    tbl.push_back(alu_row(32'hFFF00493, 4'b0010, 1, 1, 8'd64, 32'hFFFFFFFF)); // ADDI x9,x0,-1
    tbl.push_back(alu_row(32'h00148033, 4'b0111, 0, 0, 8'd68, 32'd1));        // SLT -1 < 5
    tbl.push_back(alu_row(32'h00148033, 4'b0011, 0, 0, 8'd72, 32'd0));        // undefined code
    tbl.push_back(br_row (32'hFE108CE3, 8'd76));                              // BEQ x1,x1,-8
    tbl.push_back(alu_row(32'h00300513, 4'b0010, 1, 1, 8'd68, 32'd3));        // ADDI x10 (late ctrl)
    tbl[19].late = 1'b1;
    tbl.push_back(br_row (32'h0A000A63, 8'd72));                              // BEQ x0,x0,+180
    tbl.push_back(alu_row(32'h00100593, 4'b0010, 1, 1, 8'd252, 32'd1));       // ADDI x11 at 252
    tbl.push_back(alu_row(32'h00008633, 4'b0010, 0, 1, 8'd0,  32'd5));        // wrapped to 0

    #2;
    check("rst_alu", alu_result, 32'd0);
    check("rst_req_we_retire", {29'd0, dmem_req, dmem_we, retire}, 32'd0);
    check("rst_fields", {15'd0, funct7, funct3, opcode}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) run_row(tbl[i], $sformatf("r%0d", i));

    // Reset while a store waits in MEM: the access must be dropped at once.
    imem_rdata = 32'h00202423;                                                // SW x2,8(x0)
    reg_write = 0; mem2reg = 0; alu_src = 1; mem_write = 1; mem_read = 0; branch = 0; alu_cc = 4'b0010;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (dmem_req) got = 1;
      else begin imem_ready = imem_req; @(negedge clk); end
    end
    imem_ready = 1'b0;
    check("mem_reached", 32'(got), 32'd1);
    @(negedge clk); @(negedge clk);
    #1;
    check("mem_wait_hold", {21'd0, dmem_req, dmem_we, dmem_addr}, {21'd0, 1'b1, 1'b1, 9'd8});
    reset = 1'b0;
    #1;
    check("mem_rst_drop", {30'd0, dmem_req, dmem_we}, 32'd0);
    check("mem_rst_alu", alu_result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_row(alu_row(32'h001080B3, 4'b0010, 0, 1, 8'd0, 32'd0), "pr0");       // ADD x1,x1,x1 (RF cleared)
    run_row(alu_row(32'h00500093, 4'b0010, 1, 1, 8'd4, 32'd5), "pr1");       // ADDI x1,x0,5

    // Reset while a fetch is stalled.
    imem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check("fetch_wait", {23'd0, imem_req, imem_addr}, {23'd0, 1'b1, 8'd8});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_row(alu_row(32'h00108133, 4'b0010, 0, 1, 8'd0, 32'd0), "pf0");       // ADD x2,x1,x1 after reset

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_data_path.md
MULTICYCLE_DATA_PATH -- requirements
Module: multicycle_data_path

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter width.
REQ-002 SHALL have parameter DATA_W, default 32, register/ALU data width; instruction width fixed at 32.
REQ-003 SHALL have parameter DM_ADDRESS, default 9, data-memory address width.
REQ-004 SHALL have parameter ALU_CC_W, default 4, ALU control code width.
REQ-005 SHALL have parameter PC_STEP, default 4, sequential PC increment.
REQ-006 SHALL have ports: clk  in  1  single clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-007 SHALL have control inputs, each in 1: reg_write, mem2reg, alu_src, mem_write, mem_read, branch (BEQ-style).
REQ-008 SHALL have alu_cc  in  ALU_CC_W  ALU operation select.
REQ-009 SHALL have outputs opcode out 7 = IR[6:0]; funct3 out 3 = IR[14:12]; funct7 out 7 = IR[31:25].
REQ-010 SHALL have imem_addr  out  PC_W  fetch address; imem_req  out  1  fetch request.
REQ-011 SHALL have imem_rdata  in  32  instruction; imem_ready  in  1  instruction valid this cycle.
REQ-012 SHALL have dmem_addr  out  DM_ADDRESS; dmem_req  out  1; dmem_we  out  1; dmem_wdata  out  DATA_W.
REQ-013 SHALL have dmem_rdata  in  DATA_W; dmem_ready  in  1  access complete, read data valid.
REQ-014 SHALL have alu_result  out  DATA_W  registered ALU output; retire  out  1  one-cycle instruction-complete pulse.

Function
REQ-015 SHALL implement FSM FETCH -> DECODE -> EXEC -> {MEM} -> WB -> FETCH, one instruction in flight.
REQ-016 FETCH: imem_req=1, imem_addr=PC; hold until imem_ready=1, then load IR from imem_rdata, go DECODE.
REQ-017 DECODE: latch A=RF[IR[19:15]], B=RF[IR[24:20]] and sign-extended immediate; always go EXEC.
REQ-018 Immediate: S-type (IR[31:25],IR[11:7]) when mem_write; B-type (bit0=0) when branch; else I-type IR[31:20].
REQ-019 EXEC: ALUOut <= A op (alu_src ? imm : B); alu_cc 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 signed SLT, 1100 NOR, others 0.
REQ-020 EXEC with branch=1: PC <= (A==B) ? PC+imm : PC+PC_STEP, retire pulses, go FETCH (no MEM/WB).
REQ-021 EXEC otherwise: go MEM if mem_read|mem_write, else WB.
REQ-022 MEM: dmem_req=1, dmem_we=mem_write, dmem_addr=ALUOut[DM_ADDRESS-1:0], dmem_wdata=B; hold all until dmem_ready=1; load MDR on read.
REQ-023 WB: if reg_write and rd!=0, RF[IR[11:7]] <= mem2reg ? MDR : ALUOut; PC <= PC+PC_STEP; retire=1; go FETCH.
REQ-024 Register x0 SHALL read 0 always; writes to it ignored.
REQ-025 PC arithmetic SHALL wrap modulo 2^PC_W; DATA_W arithmetic wraps, no flags.
REQ-026 Latency with zero-wait memories: ALU op 4 cycles, load/store 5, branch 3; each wait cycle adds one.
REQ-027 imem_req/dmem_req SHALL stay high and request outputs stable while ready is low.
REQ-028 Control inputs SHALL be sampled only in EXEC, MEM and WB; changes in FETCH/DECODE have no effect.

Reset
REQ-029 reset=0 SHALL immediately force state FETCH, PC=0, IR=0, A=B=ALUOut=MDR=0, all RF entries 0, imem_req (re-asserted after release), dmem_req=0, dmem_we=0, retire=0.
REQ-030 Reset during a MEM or FETCH wait SHALL abandon the access with no RF/PC update; first post-reset fetch address is 0.

Verification
REQ-031 ADDI x1,x0,5 then ADD x2,x1,x1, zero-wait -> RF[2]=10, retire every 4th cycle, PC=8.
REQ-032 SW x2,4(x0) then LW x3,4(x0) -> dmem_we=1 addr 4 wdata 10; RF[3]=10 after 5-cycle load.
REQ-033 BEQ x1,x1,+8 at PC=8 -> PC=16 after 3 cycles; BEQ with unequal regs -> PC=12.
REQ-034 imem_ready low 3 cycles, dmem_ready low 2 cycles on a load -> requests held stable, total 10 cycles, same result.
REQ-035 ADDI x0,x0,7 -> RF[0] reads 0; PC at 2^PC_W-PC_STEP plus one ALU op -> PC=0.
REQ-036 Assert reset mid-MEM wait -> dmem_req drops same cycle, no write, fetch restarts at 0.
